uart_frame_parser: RTL and testbench

//  Byte-stream to frame assembler between the UART receiver and uart_reg_mapper.

---
 rtl/uart_frame_parser.sv | 146 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Hunts a 2-byte header and assembles func + payload + checksum frames
//            from the UART byte stream, then publishes good frames atomically.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
  parameter logic [7:0] _HEAD0       = 8'h55,
  parameter logic [7:0] _HEAD1       = 8'hAA,
  parameter int         _DATA_LEN    = 10,
  parameter int         _TIMEOUT_CYC = 50000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic [7:0] func_reg,
  output logic [7:0] rev_data1,
  output logic [7:0] rev_data2,
  output logic [7:0] rev_data3,
  output logic [7:0] rev_data4,
  output logic [7:0] rev_data5,
  output logic [7:0] rev_data6,
  output logic [7:0] rev_data7,
  output logic [7:0] rev_data8,
  output logic [7:0] rev_data9,
  output logic [7:0] rev_data10,
  output logic       pack_done,
  output logic       pack_err,
  output logic       busy
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_HEAD1 = 3'd1;
  localparam logic [2:0] c_S_FUNC  = 3'd2;
  localparam logic [2:0] c_S_DATA  = 3'd3;
  localparam logic [2:0] c_S_CSUM  = 3'd4;

  localparam int         c_TW       = $clog2(_TIMEOUT_CYC);
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(_TIMEOUT_CYC - 1);
  localparam logic [3:0] c_LAST_IDX = 4'(_DATA_LEN - 1);

  logic [2:0]      r_state;
  logic [3:0]      r_idx;
  logic [7:0]      r_csum;
  logic [c_TW-1:0] r_timer;
  logic [7:0]      r_shadow_func;
  logic [7:0]      r_shadow [0:_DATA_LEN-1];
  logic            w_match;

  assign busy    = (r_state != c_S_IDLE);
  assign w_match = uart_rx_done && (r_state == c_S_CSUM) && (uart_rx_data == r_csum);

  // Control path: a strobe always takes precedence over timeout expiry.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_S_IDLE;
      r_idx     <= 4'd0;
      r_csum    <= 8'd0;
      r_timer   <= '0;
      pack_done <= 1'b0;
      pack_err  <= 1'b0;
    end else begin
      pack_done <= 1'b0;
      pack_err  <= 1'b0;
      if (uart_rx_done) begin
        r_timer <= '0;
        case (r_state)
          c_S_IDLE: begin
            if (uart_rx_data == _HEAD0) r_state <= c_S_HEAD1;
          end
          c_S_HEAD1: begin
            if (uart_rx_data == _HEAD1)      r_state <= c_S_FUNC;
            else if (uart_rx_data != _HEAD0) r_state <= c_S_IDLE;
          end
          c_S_FUNC: begin
            r_csum  <= uart_rx_data;
            r_idx   <= 4'd0;
            r_state <= c_S_DATA;
          end
          c_S_DATA: begin
            r_csum <= r_csum + uart_rx_data;
            r_idx  <= r_idx + 4'd1;
            if (r_idx == c_LAST_IDX) r_state <= c_S_CSUM;
          end
          c_S_CSUM: begin
            if (uart_rx_data == r_csum) pack_done <= 1'b1;
            else                        pack_err  <= 1'b1;
            r_state <= c_S_IDLE;
          end
          default: r_state <= c_S_IDLE;
        endcase
      end else if (r_state == c_S_IDLE) begin
        r_timer <= '0;
      end else if (r_timer == c_TMAX) begin
        r_timer  <= '0;
        r_state  <= c_S_IDLE;
        pack_err <= 1'b1;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_func <= 8'd0;
      for (int i = 0; i < _DATA_LEN; i++) r_shadow[i] <= 8'd0;
    end else if (uart_rx_done) begin
      if (r_state == c_S_FUNC) r_shadow_func <= uart_rx_data;
      if (r_state == c_S_DATA) r_shadow[r_idx] <= uart_rx_data;
    end
  end

  // Outputs move only as a complete set, on the edge that raises pack_done.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      func_reg   <= 8'd0;
      rev_data1  <= 8'd0;
      rev_data2  <= 8'd0;
      rev_data3  <= 8'd0;
      rev_data4  <= 8'd0;
      rev_data5  <= 8'd0;
      rev_data6  <= 8'd0;
      rev_data7  <= 8'd0;
      rev_data8  <= 8'd0;
      rev_data9  <= 8'd0;
      rev_data10 <= 8'd0;
    end else if (w_match) begin
      func_reg   <= r_shadow_func;
      rev_data1  <= r_shadow[0];
      rev_data2  <= r_shadow[1];
      rev_data3  <= r_shadow[2];
      rev_data4  <= r_shadow[3];
      rev_data5  <= r_shadow[4];
      rev_data6  <= r_shadow[5];
      rev_data7  <= r_shadow[6];
      rev_data8  <= r_shadow[7];
      rev_data9  <= r_shadow[8];
      rev_data10 <= r_shadow[9];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Brief    : Scoreboard bench for uart_frame_parser with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

  localparam int c_TIMEOUT = 50000;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx_done = 1'b0;
  logic [7:0] uart_rx_data = 8'd0;
  logic [7:0] func_reg;
  logic [7:0] rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
  logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
  logic       pack_done, pack_err, busy;

  uart_frame_parser dut (
    .clk_50M      (clk_50M),
    .rst_n        (rst_n),
    .uart_rx_done (uart_rx_done),
    .uart_rx_data (uart_rx_data),
    .func_reg     (func_reg),
    .rev_data1    (rev_data1),
    .rev_data2    (rev_data2),
    .rev_data3    (rev_data3),
    .rev_data4    (rev_data4),
    .rev_data5    (rev_data5),
    .rev_data6    (rev_data6),
    .rev_data7    (rev_data7),
    .rev_data8    (rev_data8),
    .rev_data9    (rev_data9),
    .rev_data10   (rev_data10),
    .pack_done    (pack_done),
    .pack_err     (pack_err),
    .busy         (busy)
  );

  always #10 clk_50M = ~clk_50M;

  // Payload byte i sits at bits [8*i +: 8], so rev_data1 is the low byte.
  logic [79:0] w_data;
  assign w_data = {rev_data10, rev_data9, rev_data8, rev_data7, rev_data6,
                   rev_data5, rev_data4, rev_data3, rev_data2, rev_data1};

  typedef struct packed {
    logic        err;
    logic [7:0]  func;
    logic [79:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  g_func = 8'd0;
  logic [79:0] g_data = 80'd0;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_50M) begin
    if (rst_n && (pack_done || pack_err)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse", pack_done, pack_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind", 88'({pack_err, pack_done}), 88'({e.err, ~e.err}));
        check("func_reg", 88'(func_reg), 88'(e.func));
        check("rev_data", 88'(w_data), 88'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_done = 1'b1;
    @(posedge clk_50M);
    #1;
    uart_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] f, input logic [79:0] d, input logic bad);
    logic [7:0] cs;
    exp_t e;
    cs = f;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(f);
    for (int i = 0; i < 10; i++) begin
      cs = cs + d[8*i +: 8];
      send_byte(d[8*i +: 8]);
    end
    if (bad) cs = cs + 8'd1;
    else begin
      g_func = f;
      g_data = d;
    end
    e.err  = bad;
    e.func = g_func;
    e.data = g_data;
    q.push_back(e);
    send_byte(cs);
  endtask

  logic [79:0] d1, d5a, d5b, d6;

  initial begin
    // Frame 1: 00 00 05 00 0A 03 12 34 56 78, checksum 0x27
    d1  = {8'h78, 8'h56, 8'h34, 8'h12, 8'h03, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h00};
    d5a = {8'h0A, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    d5b = {8'hFF, 8'h55, 8'hAA, 8'h80, 8'h7F, 8'h10, 8'h20, 8'h30, 8'h40, 8'hC0};
    d6  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

    idle(3);
    check("reset_outputs", {func_reg, w_data}, 88'd0);
    check("reset_flags", 88'({pack_done, pack_err, busy}), 88'd0);
    rst_n = 1'b1;
    idle(2);

    send_frame(8'h01, d1, 1'b0);
    idle(1);
    check("t1_func_rd1_rd3_rd10", 88'({func_reg, rev_data1, rev_data3, rev_data10}),
          88'({8'h01, 8'h00, 8'h05, 8'h78}));
    idle(3);

    send_frame(8'h01, d1, 1'b1);
    idle(3);
    check("t2_outputs_held", {func_reg, w_data}, {8'h01, d1});

    send_byte(8'h55);
    send_frame(8'h02, 80'd0, 1'b0);
    idle(3);

    send_byte(8'h55);
    send_byte(8'hAA);
    check("t4_busy_in_frame", 88'(busy), 88'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    begin
      exp_t e;
      e.err = 1'b1; e.func = g_func; e.data = g_data;
      q.push_back(e);
    end
    idle(c_TIMEOUT - 1);
    check("t4_no_early_timeout", 88'({pack_err, busy}), 88'({1'b0, 1'b1}));
    idle(1);
    check("t4_timeout_pulse", 88'({pack_err, busy}), 88'({1'b1, 1'b0}));
    idle(2);
    send_frame(8'h04, d6, 1'b0);
    idle(3);

    send_frame(8'h05, d5a, 1'b0);
    send_frame(8'h06, d5b, 1'b0);
    idle(1);
    check("t5_second_frame", {func_reg, w_data}, {8'h06, d5b});
    idle(3);

    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h07);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    rst_n = 1'b0;
    g_func = 8'd0;
    g_data = 80'd0;
    idle(2);
    check("t6_reset_outputs", {func_reg, w_data}, 88'd0);
    check("t6_reset_flags", 88'({pack_done, pack_err, busy}), 88'd0);
    rst_n = 1'b1;
    idle(4);
    check("t6_no_pulse_after_release", 88'({pack_done, pack_err}), 88'd0);
    send_frame(8'h08, d6, 1'b0);
    idle(1);
    check("t6_frame_after_reset", {func_reg, w_data}, {8'h08, d6});
    idle(5);

    check("scoreboard_drained", 88'(q.size()), 88'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
